// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-sweep FSM state encoding and the address-width helper.
package regfile_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the register file's write/read/scoreboard/clear signals.
// The master side drives requests; the slave side is the register file.
interface regfile_mp_if #(
   parameter int XLEN = 32,
   parameter int NRD  = 2,
   parameter int AW   = 5
) ();
   logic                we;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rpend;
   logic                claim_en;
   logic [AW-1:0]       claim_addr;
   logic                clr_req;
   logic                busy;
   logic                wr_drop;

   modport master (
      output we, waddr, wdata, raddr, claim_en, claim_addr, clr_req,
      input  rdata, rpend, busy, wr_drop
   );

   modport slave (
      input  we, waddr, wdata, raddr, claim_en, claim_addr, clr_req,
      output rdata, rpend, busy, wr_drop
   );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: walks clr_idx over every register once, one per cycle.
// Reset parks it in CLEAR at index 0 so a full sweep follows reset release.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int  NREGS = 32,
   localparam int AW    = clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req_i,
   output logic          busy_o,
   output logic          clr_start_o,
   output logic [AW-1:0] clr_idx_o
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      clr_start_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req_i) begin
               state_d     = ST_CLEAR;
               idx_d       = '0;
               clr_start_o = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_o    = (state_q == ST_CLEAR);
   assign clr_idx_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write forwarding, per-register pending
// scoreboard and a one-register-per-cycle clear sweep.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int  XLEN     = 32,
   parameter int  NREGS    = 32,
   parameter int  NRD      = 2,
   parameter int  BYPASS   = 1,
   parameter int  ZERO_REG = 1,
   localparam int AW       = clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rpend,
   input  logic                claim_en,
   input  logic [AW-1:0]       claim_addr,
   input  logic                clr_req,
   output logic                busy,
   output logic                wr_drop
);

   localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] pend_q, pend_d;
   logic [AW-1:0]    clr_idx;
   logic             clr_start;
   logic             wr_acc;
   logic             claim_acc;
   logic             wr_drop_q;

   // In range and not the hardwired zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   regfile_clr_fsm #(.NREGS(NREGS)) u_clr_fsm (
      .clk         (clk),
      .rst         (rst),
      .clr_req_i   (clr_req),
      .busy_o      (busy),
      .clr_start_o (clr_start),
      .clr_idx_o   (clr_idx)
   );

   assign wr_acc    = we && !busy && addr_ok(waddr);
   assign claim_acc = claim_en && !busy && addr_ok(claim_addr);

   always_ff @(posedge clk) begin
      if (busy) begin
         regs_q[clr_idx] <= '0;
      end else if (wr_acc) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Claim is applied after the write-clear so a same-cycle claim wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_acc)    pend_d[waddr]      = 1'b0;
      if (claim_acc) pend_d[claim_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_start) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_drop_q <= 1'b0;
      end else begin
         wr_drop_q <= we && !wr_acc;
      end
   end

   assign wr_drop = wr_drop_q;

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd_val;

      assign ra = raddr[gi*AW +: AW];

      always_comb begin
         rd_val = '0;
         if (!busy && addr_ok(ra)) begin
            if ((BYPASS != 0) && wr_acc && (waddr == ra)) begin
               rd_val = wdata;
            end else begin
               rd_val = regs_q[ra];
            end
         end
      end

      assign rdata[gi*XLEN +: XLEN] = rd_val;
      assign rpend[gi]              = addr_ok(ra) && pend_q[ra];
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of registers (2..64).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enabled when 1.
REQ-005 SHALL have parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-006 SHALL use AW = clog2(NREGS) for all address ports.
REQ-007 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-008 SHALL have port rst  input  1  synchronous active-high reset.
REQ-009 SHALL have port we  input  1  write enable.
REQ-010 SHALL have port waddr  input  AW  write address.
REQ-011 SHALL have port wdata  input  XLEN  write data.
REQ-012 SHALL have port raddr  input  NRD*AW  packed read addresses, port k at [k*AW +: AW].
REQ-013 SHALL have port rdata  output  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
REQ-014 SHALL have port rpend  output  NRD  pending bit of register addressed by each read port.
REQ-015 SHALL have port claim_en  input  1  mark claim_addr pending (destination issued).
REQ-016 SHALL have port claim_addr  input  AW  register to mark pending.
REQ-017 SHALL have port clr_req  input  1  request a full zero sweep of the file.
REQ-018 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-019 SHALL have port wr_drop  output  1  one-cycle pulse when a write is discarded.

Function
REQ-020 SHALL implement a two-state FSM: IDLE, CLEAR.
REQ-021 SHALL, in CLEAR, zero one register per cycle at index clr_idx, incrementing 0..NREGS-1, then return to IDLE; sweep takes exactly NREGS cycles.
REQ-022 SHALL deassert busy in the cycle after index NREGS-1 is zeroed.
REQ-023 SHALL, on clr_req in IDLE, enter CLEAR next cycle with clr_idx=0; clr_req while in CLEAR is ignored.
REQ-024 SHALL, in IDLE with we=1, waddr<NREGS, and (waddr!=0 or ZERO_REG=0), write wdata at next rising edge.
REQ-025 SHALL discard writes while busy, to waddr>=NREGS, or to register 0 when ZERO_REG=1, and pulse wr_drop for each discarded write with we=1.
REQ-026 SHALL drive rdata combinationally; return 0 when busy, raddr>=NREGS, or raddr=0 with ZERO_REG=1.
REQ-027 SHALL, when BYPASS=1, not busy, and a write per REQ-024 targets raddr, return wdata on that port in the same cycle.
REQ-028 SHALL keep one pending bit per register: set by claim_en, cleared by an accepted write to that address.
REQ-029 SHALL, on simultaneous claim and accepted write to the same address, leave the bit set (claim wins).
REQ-030 SHALL ignore claim_en while busy, for claim_addr>=NREGS, and for register 0 when ZERO_REG=1.
REQ-031 SHALL clear all pending bits in the cycle CLEAR is entered.
REQ-032 SHALL drive rpend combinationally; 0 for out-of-range or hardwired-zero addresses.

Reset
REQ-033 SHALL, while rst=1, hold state=CLEAR, clr_idx=0, busy=1, wr_drop=0, all pending bits 0.
REQ-034 SHALL begin the sweep on the first edge with rst=0; rst mid-sweep restarts from index 0.

Structure
REQ-035 SHALL place the FSM state enum and clog2 helper in shared package regfile_pkg.
REQ-036 SHALL implement the FSM and clr_idx counter in sub-module regfile_clr_fsm.

Verification
REQ-037 SHALL test reset: rst 3 cycles, release -> busy high exactly 32 cycles, then all reads return 0.
REQ-038 SHALL test bypass: write x5=0xDEADBEEF, raddr port0=5 same cycle -> rdata0=0xDEADBEEF; with BYPASS=0 -> old value.
REQ-039 SHALL test zero reg: write x0=0x1234 -> wr_drop pulse, read x0 = 0.
REQ-040 SHALL test scoreboard: claim x7, next cycle rpend=1; write x7 and claim x7 same cycle -> rpend stays 1; write only -> 0.
REQ-041 SHALL test clear: fill x1..x31, clr_req -> busy 32 cycles, writes during sweep pulse wr_drop, all reads 0 after.
REQ-042 SHALL test parameters NREGS=16, NRD=4: write to addr 15 accepted, all four ports read it concurrently.
